// File: rtl/dp_seq_pkg.sv
// rtl/dp_seq_pkg.sv - shared types, constants and tail-mask helper for dot_product_seq
package dp_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;

    localparam logic signed [LANE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [LANE_W-1:0] SAT_MIN = 16'sh8000;

    // Only the last group of a vector whose length is not a multiple of 4 is partial.
    function automatic logic [LANES-1:0] tail_mask(input logic [1:0] rem, input logic last);
        logic [LANES-1:0] m;
        m = '1;
        if (last && (rem != 2'd0)) begin
            for (int i = 0; i < LANES; i++) begin
                m[i] = (i < int'(rem));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dot_product_seq_if.sv
// rtl/dot_product_seq_if.sv - request, memory, datapath and result signals of dot_product_seq
interface dot_product_seq_if
    import dp_seq_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic                       start;
    logic [ADDR_W+2:0]          len;
    logic [ADDR_W-1:0]          base_a;
    logic [ADDR_W-1:0]          base_b;
    logic                       busy;

    logic                       rd_en;
    logic [ADDR_W-1:0]          rd_addr_a;
    logic [ADDR_W-1:0]          rd_addr_b;
    logic [LANES*LANE_W-1:0]    rd_data_a;
    logic [LANES*LANE_W-1:0]    rd_data_b;

    logic                       mul_en;
    logic [LANES*LANE_W-1:0]    mul_a;
    logic [LANES*LANE_W-1:0]    mul_b;
    logic                       mul_valid;
    logic signed [LANE_W-1:0]   mul_sum;

    logic                       res_valid;
    logic                       res_ready;
    logic signed [LANE_W-1:0]   res_data;

    modport master (
        input  start, len, base_a, base_b,
        input  rd_data_a, rd_data_b,
        input  mul_valid, mul_sum,
        input  res_ready,
        output busy,
        output rd_en, rd_addr_a, rd_addr_b,
        output mul_en, mul_a, mul_b,
        output res_valid, res_data
    );

    modport slave (
        output start, len, base_a, base_b,
        output rd_data_a, rd_data_b,
        output mul_valid, mul_sum,
        output res_ready,
        input  busy,
        input  rd_en, rd_addr_a, rd_addr_b,
        input  mul_en, mul_a, mul_b,
        input  res_valid, res_data
    );

endinterface

// File: rtl/sat_add16.sv
// rtl/sat_add16.sv - combinational 16+16 -> 16 signed saturating adder
module sat_add16
    import dp_seq_pkg::*;
(
    input  logic signed [LANE_W-1:0] a_i,
    input  logic signed [LANE_W-1:0] b_i,
    output logic signed [LANE_W-1:0] sum_o
);

    logic signed [LANE_W:0] wide;

    assign wide = {a_i[LANE_W-1], a_i} + {b_i[LANE_W-1], b_i};

    // The 17-bit sum leaves 16-bit range exactly when its top two bits differ.
    always_comb begin
        sum_o = wide[LANE_W-1:0];
        if (wide[LANE_W] != wide[LANE_W-1]) begin
            sum_o = wide[LANE_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/dot_product_seq.sv
// rtl/dot_product_seq.sv - sequences one dot product over a shared 4-lane multiply-sum datapath
module dot_product_seq
    import dp_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    dot_product_seq_if.master bus
);

    localparam int CNT_W = ADDR_W + 1;

    if (LAT < 1) begin : g_bad_lat
        $error("dot_product_seq: LAT must be at least 1");
    end

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        base_a_q, base_a_d;
    logic [ADDR_W-1:0]        base_b_q, base_b_d;
    logic [CNT_W-1:0]         groups_q, groups_d;
    logic [CNT_W-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]         done_cnt_q, done_cnt_d;
    logic [1:0]               rem_q, rem_d;
    logic signed [LANE_W-1:0] acc_q, acc_d;
    logic                     mul_en_q;
    logic                     mul_last_q;

    logic [CNT_W-1:0]         len_groups;
    logic [CNT_W-1:0]         done_next;
    logic                     issue_last;
    logic                     accum_en;
    logic signed [LANE_W-1:0] acc_sum;
    logic [LANES-1:0]         lane_mask;
    logic [LANES*LANE_W-1:0]  mul_a_w;
    logic [LANES*LANE_W-1:0]  mul_b_w;

    assign len_groups = CNT_W'(bus.len[ADDR_W+2:2]) + CNT_W'(|bus.len[1:0]);
    assign issue_last = (issue_cnt_q == groups_q - 1'b1);
    assign accum_en   = bus.mul_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign done_next  = done_cnt_q + CNT_W'(accum_en);

    sat_add16 u_sat_add16 (
        .a_i   (acc_q),
        .b_i   (bus.mul_sum),
        .sum_o (acc_sum)
    );

    always_comb begin
        state_d     = state_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        groups_d    = groups_q;
        rem_d       = rem_q;
        issue_cnt_d = issue_cnt_q;
        done_cnt_d  = done_next;
        acc_d       = accum_en ? acc_sum : acc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_a_d    = bus.base_a;
                    base_b_d    = bus.base_b;
                    groups_d    = len_groups;
                    rem_d       = bus.len[1:0];
                    issue_cnt_d = '0;
                    done_cnt_d  = '0;
                    acc_d       = '0;
                    state_d     = (len_groups == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_last) begin
                    state_d = S_DRAIN;
                end
            end
            // Look at the count including this cycle's pulse so DONE follows the last sum directly.
            S_DRAIN: begin
                if (done_next == groups_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_a_q    <= '0;
            base_b_q    <= '0;
            groups_q    <= '0;
            rem_q       <= '0;
            issue_cnt_q <= '0;
            done_cnt_q  <= '0;
            acc_q       <= '0;
            mul_en_q    <= 1'b0;
            mul_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            groups_q    <= groups_d;
            rem_q       <= rem_d;
            issue_cnt_q <= issue_cnt_d;
            done_cnt_q  <= done_cnt_d;
            acc_q       <= acc_d;
            mul_en_q    <= bus.rd_en;
            mul_last_q  <= bus.rd_en && issue_last;
        end
    end

    // Read data arrives one cycle after rd_en, aligned with mul_en and its tail flag.
    assign lane_mask = tail_mask(rem_q, mul_last_q);

    always_comb begin
        mul_a_w = '0;
        mul_b_w = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mul_en_q && lane_mask[i]) begin
                mul_a_w[LANE_W*i +: LANE_W] = bus.rd_data_a[LANE_W*i +: LANE_W];
                mul_b_w[LANE_W*i +: LANE_W] = bus.rd_data_b[LANE_W*i +: LANE_W];
            end
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rd_en     = (state_q == S_ISSUE);
    assign bus.rd_addr_a = base_a_q + issue_cnt_q[ADDR_W-1:0];
    assign bus.rd_addr_b = base_b_q + issue_cnt_q[ADDR_W-1:0];
    assign bus.mul_en    = mul_en_q;
    assign bus.mul_a     = mul_a_w;
    assign bus.mul_b     = mul_b_w;
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_data  = acc_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// tb/tb_dot_product_seq.sv - scoreboard bench for dot_product_seq with memory and datapath models
module tb_dot_product_seq;
    import dp_seq_pkg::*;

    localparam int ADDR_W = 8;
    localparam int LAT    = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_product_seq_if #(.ADDR_W(ADDR_W)) bus ();

    dot_product_seq #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] mem_a [DEPTH];
    logic [63:0] mem_b [DEPTH];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem_a[bus.rd_addr_a];
            bus.rd_data_b <= mem_b[bus.rd_addr_b];
        end
    end

    function automatic logic signed [15:0] lane_sum(input logic [63:0] a, input logic [63:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += int'($signed(a[16*i +: 16])) * int'($signed(b[16*i +: 16]));
        end
        return s[15:0];
    endfunction

    logic [LAT-1:0]     vpipe = '0;
    logic signed [15:0] spipe [LAT];

    always @(posedge clk) begin
        vpipe    <= {vpipe[LAT-2:0], bus.mul_en};
        spipe[0] <= lane_sum(bus.mul_a, bus.mul_b);
        for (int i = 1; i < LAT; i++) spipe[i] <= spipe[i-1];
    end

    assign bus.mul_valid = vpipe[LAT-1];
    assign bus.mul_sum   = spipe[LAT-1];

    int                 n_cmp = 0;
    int                 n_bad = 0;
    logic signed [15:0] sb_q [$];
    logic [63:0]        cap_a [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input bit sel_b, input int grp, input int lane, input int val);
        if (sel_b) mem_b[grp % DEPTH][16*lane +: 16] = 16'(val);
        else       mem_a[grp % DEPTH][16*lane +: 16] = 16'(val);
    endtask

    function automatic logic signed [15:0] ref_dot(input int l, input int ba, input int bb);
        int                 acc;
        int                 s;
        logic signed [15:0] s16;
        acc = 0;
        for (int g = 0; g < (l + 3) / 4; g++) begin
            s = 0;
            for (int ln = 0; ln < 4; ln++) begin
                if (g*4 + ln < l)
                    s += int'($signed(mem_a[(ba+g) % DEPTH][16*ln +: 16]))
                       * int'($signed(mem_b[(bb+g) % DEPTH][16*ln +: 16]));
            end
            s16 = s[15:0];
            acc += s16;
            if (acc > 32767)  acc = 32767;
            if (acc < -32768) acc = -32768;
        end
        return acc[15:0];
    endfunction

    task automatic run(input int l, input int ba, input int bb, input int exp_cyc, input int hold);
        int                 g, cyc, rdc, mlc;
        logic signed [15:0] e;
        g = (l + 3) / 4;
        sb_q.push_back(ref_dot(l, ba, bb));
        cap_a.delete();
        @(negedge clk);
        bus.start  = 1'b1;
        bus.len    = 11'(l);
        bus.base_a = 8'(ba);
        bus.base_b = 8'(bb);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; rdc = 0; mlc = 0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        while (!bus.res_valid && cyc < 500) begin
            if (bus.rd_en) rdc++;
            if (bus.mul_en) begin
                mlc++;
                cap_a.push_back(bus.mul_a);
            end
            @(negedge clk);
            cyc++;
        end
        chk("res_valid_seen", 64'(bus.res_valid), 64'd1);
        chk("latency", 64'(cyc), 64'(exp_cyc));
        chk("rd_pulses", 64'(rdc), 64'(g));
        chk("mul_pulses", 64'(mlc), 64'(g));
        for (int h = 0; h < hold; h++) begin
            bus.start = 1'b1;
            bus.len   = 11'd4;
            @(negedge clk);
            bus.start = 1'b0;
            chk("hold_valid", 64'(bus.res_valid), 64'd1);
            chk("hold_data", 64'(bus.res_data), 64'(sb_q[0]));
        end
        bus.res_ready = 1'b1;
        e = sb_q.pop_front();
        chk("res_data", 64'(bus.res_data), 64'(e));
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("idle_after_hs", 64'(bus.busy), 64'd0);
        chk("valid_drop", 64'(bus.res_valid), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      64'(bus.busy),      64'd0);
        chk({tag, "_rd_en"},     64'(bus.rd_en),     64'd0);
        chk({tag, "_rd_addr_a"}, 64'(bus.rd_addr_a), 64'd0);
        chk({tag, "_rd_addr_b"}, 64'(bus.rd_addr_b), 64'd0);
        chk({tag, "_mul_en"},    64'(bus.mul_en),    64'd0);
        chk({tag, "_mul_a"},     bus.mul_a,          64'd0);
        chk({tag, "_mul_b"},     bus.mul_b,          64'd0);
        chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        chk({tag, "_res_data"},  64'(bus.res_data),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stale;
        bus.start = 1'b0; bus.len = '0; bus.base_a = '0; bus.base_b = '0; bus.res_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            set_lane(0, 0, i, i + 1);   set_lane(1, 0, i, 1);
            set_lane(0, 4, i, i + 1);   set_lane(1, 4, i, 2);
            set_lane(0, 20 + i, i, 7);  set_lane(1, 20 + i, i, 7);
        end
        set_lane(0, 5, 0, 5);   set_lane(0, 5, 1, 6);   set_lane(0, 5, 2, 100); set_lane(0, 5, 3, 100);
        set_lane(1, 5, 0, 2);   set_lane(1, 5, 1, 2);   set_lane(1, 5, 2, 100); set_lane(1, 5, 3, 100);
        set_lane(0, 8, 0, 30000);   set_lane(0, 9, 0, 5000);
        set_lane(0, 10, 0, -30000); set_lane(0, 11, 0, -5000);
        set_lane(0, 12, 0, 30000);  set_lane(0, 13, 0, 5000);  set_lane(0, 14, 0, -10000);
        for (int g = 8; g < 15; g++) set_lane(1, g, 0, 1);
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 4; i++) begin
                set_lane(0, 254 + g, i, int'($urandom_range(0, 400)) - 200);
                set_lane(1, 100 + g, i, int'($urandom_range(0, 400)) - 200);
            end
        end

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        run(4, 0, 0, 6, 0);
        run(6, 4, 4, 7, 0);
        chk("g1_mask_hi", {32'd0, cap_a[1][63:32]}, 64'd0);
        chk("g1_keep_lo", {32'd0, cap_a[1][31:0]}, {32'd0, 16'd6, 16'd5});
        run(8, 8, 8, 7, 0);
        chk("sat_pos_ref", 64'(ref_dot(8, 8, 8)), 64'(16'sh7FFF));
        run(8, 10, 10, 7, 0);
        chk("sat_neg_ref", 64'(ref_dot(8, 10, 10)), 64'(16'sh8000));
        run(12, 12, 12, 8, 0);
        run(0, 0, 0, 1, 0);
        run(4, 0, 0, 6, 5);
        run(13, 254, 100, 9, 0);

        @(negedge clk);
        bus.start = 1'b1; bus.len = 11'd16; bus.base_a = 8'd20; bus.base_b = 8'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("midrst");
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.mul_valid) stale++;
        end
        chk("stale_pulses", 64'(stale > 0), 64'd1);
        chk("stale_busy", 64'(bus.busy), 64'd0);
        chk("stale_acc", 64'(bus.res_data), 64'd0);
        run(4, 0, 0, 6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dot_product_seq.md
# dot_product_seq

Sequencer that computes a signed 16-bit dot product of length `len` using a shared 4-lane multiply-sum datapath (four 16x16 lanes feeding one adder, `LAT`-cycle pipeline). It reads operand groups from two vector memories, issues one group of 4 lanes per cycle with zero-masked tail lanes, and accumulates the datapath's per-group sums with saturation. It returns one result per `start` over a valid/ready handshake. It sits between the GRU gate scheduler and the 4-lane datapath.

## Interface
- `ADDR_W`, 8: group-address width; max `len` = 4·2^ADDR_W
- `LAT`, 3: datapath latency, `mul_en` -> `mul_valid`
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle request; sampled only in IDLE
- `len` in ADDR_W+3: element count, 0..4·2^ADDR_W
- `base_a`, `base_b` in ADDR_W: first group address of each vector
- `busy` out 1: high from the cycle after an accepted `start` until the result handshake completes
- `rd_en` out 1: memory read strobe; data returns 1 cycle later
- `rd_addr_a`, `rd_addr_b` out ADDR_W: group addresses; wrap modulo 2^ADDR_W
- `rd_data_a`, `rd_data_b` in 64: lanes 0..3 in bits [16i+15:16i], signed
- `mul_en` out 1: issue one group to the datapath
- `mul_a`, `mul_b` out 64: lane operands, masked
- `mul_valid` in 1: one pulse per issued group, LAT cycles after `mul_en`
- `mul_sum` in 16 signed: group sum, valid with `mul_valid`
- `res_valid` out 1: result available
- `res_ready` in 1: consumer accept
- `res_data` out 16 signed: saturated dot product

## Operation
- G = ceil(len/4), the number of groups. The tail group masks lanes i ≥ (len mod 4) to 0 on both `mul_a` and `mul_b`. When len mod 4 = 0, nothing is masked.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: `start`=1 with len>0 -> ISSUE. Latch `base_a`, `base_b`, and G. Clear the accumulator and both counters.
  - IDLE: `start`=1 with len=0 -> DONE with accumulator 0.
  - ISSUE: `rd_en`=1 and addresses = base + issue count. Advance the count every cycle. After G reads -> DRAIN.
  - DRAIN: wait until the `mul_valid` pulse count reaches G -> DONE.
  - DONE: `res_valid`=1, `res_data` = accumulator. `res_valid && res_ready` -> IDLE.
- `mul_en` is `rd_en` delayed by 1 cycle. `mul_a`/`mul_b` are the registered-through read data with the mask applied for that group.
- On each `mul_valid`, acc <= sat16(acc + mul_sum). Compute the sum at 17 bits, then clamp to [-32768, 32767]. Saturation is sticky only through the value; later terms may pull the accumulator back into range.
- `start` is ignored outside IDLE.
- A `mul_valid` outside ISSUE/DRAIN is ignored.
- `rst` at any cycle returns the block to IDLE next edge and drops all in-flight groups. After reset, stale `mul_valid` pulses arriving in IDLE are ignored.

## Timing
- Reset values: `busy`=0, `rd_en`=0, `rd_addr_a`/`rd_addr_b`=0, `mul_en`=0, `mul_a`/`mul_b`=0, `res_valid`=0, `res_data`=0. Internal accumulator and counters are also 0.
- `start` accepted at cycle 0:
  - `rd_en` high cycles 1..G
  - `mul_en` high cycles 2..G+1
  - `mul_valid` expected at cycles 2+LAT..G+1+LAT
  - `res_valid` rises at cycle G+2+LAT (LAT=3, G=1 -> cycle 6)
- len=0: `res_valid` rises at cycle 1 with `res_data`=0.
- `res_data` is stable while `res_valid`=1 and `res_ready`=0.
- Handshake at cycle t: IDLE at t+1. A new `start` is accepted at t+1 at the earliest.
- Throughput: one group per cycle. No bubbles inside ISSUE.

## Structure
- Package `dp_seq_pkg` holds:
  - the state enum
  - `SAT_MAX`=16'sh7FFF and `SAT_MIN`=16'sh8000
  - `LANES`=4 and `LANE_W`=16
  - the function for the tail lane mask
- One sub-module, `sat_add16`: combinational 16+16 -> 16 signed saturating adder used by the accumulator.
- The 4-lane datapath is external and is connected at the top level.

## Test plan
- len=4 with a=[1,2,3,4], b=[1,1,1,1], LAT=3 datapath model -> `res_data`=10 at cycle 6. Exactly 1 `rd_en` pulse and 1 `mul_en` pulse.
- len=6 with a=[1..6] and b all 2, memory lanes 6,7 preloaded with 100 -> group-1 `mul_a` lanes 2,3 = 0. `res_data`=42 at cycle 7.
- len=8 with injected group sums 30000 and 5000 -> `res_data`=32767. Then len=8 with sums -30000 and -5000 -> -32768.
- len=0 -> `res_valid` at cycle 1, `res_data`=0, no `rd_en`.
- Hold `res_ready`=0 for 5 cycles in DONE while pulsing `start` -> `res_data` is held, the `start` is ignored, and IDLE follows the accepting cycle.
- `rst` pulsed mid-ISSUE with len=16 -> all outputs at reset values next cycle. Later `mul_valid` pulses are ignored. A following len=4 run yields the correct result.
